// File: rtl/sm_regdump_uart_if.sv
// Register-readout and UART-status bundle between the dump engine and its surroundings.
// The master side drives regAddr and the UART/status outputs; the slave side answers with regData.
interface sm_regdump_uart_if;
  logic        start;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (input start, input regData, output regAddr, output tx, output busy, output done);
  modport slave  (output start, output regData, input regAddr, input tx, input busy, input done);
endinterface

// File: rtl/sm_regdump_uart.sv
// Walks regAddr 0..LAST_REG, captures each regData after a settle delay, and prints it
// as "II:DDDDDDDD\r\n" over an 8N1 UART; busy spans the dump, done pulses once at the end.
module sm_regdump_uart #(
  parameter int BAUD_DIV = 434,
  parameter int SETTLE   = 8,
  parameter int LAST_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  sm_regdump_uart_if.master bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_SHIFT   = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [4:0]  ADDR_LAST   = 5'(LAST_REG);

  logic [2:0]  state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  char_q, char_d;
  logic [31:0] shadow_q, shadow_d;
  logic [8:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [2:0]  nib_idx;
  logic [7:0]  char_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'(8'h37 + {4'h0, n});
  endfunction

  // chars 3..10 walk the shadow nibbles 7..0, MSB first
  always_comb begin
    nib_idx   = 3'(4'd10 - char_q);
    char_byte = 8'h00;
    case (char_q)
      4'd0:    char_byte = hex_ascii({3'b000, addr_q[4]});
      4'd1:    char_byte = hex_ascii(addr_q[3:0]);
      4'd2:    char_byte = 8'h3A;
      4'd11:   char_byte = 8'h0D;
      4'd12:   char_byte = 8'h0A;
      default: char_byte = hex_ascii(shadow_q[{nib_idx, 2'b00} +: 4]);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    settle_d = settle_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    char_d   = char_q;
    shadow_d = shadow_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_SETTLE;
          addr_d   = '0;
          settle_d = '0;
          char_d   = '0;
          busy_d   = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_CAPTURE;
        else                         settle_d = settle_q + 8'd1;
      end
      S_CAPTURE: begin
        shadow_d = bus.regData;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        shift_d = {1'b1, char_byte};
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            tx_d = 1'b1;
            if (char_q == 4'd12) begin
              state_d = S_NEXT;
            end else begin
              char_d  = char_q + 4'd1;
              state_d = S_LOAD;
            end
          end else begin
            // bit 8 shifts out the stop bit parked in shift_q[8]
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_NEXT: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_FINISH;
        end else begin
          addr_d   = addr_q + 5'd1;
          char_d   = '0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      settle_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      char_q   <= '0;
      shadow_q <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      settle_q <= settle_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.regAddr = addr_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_sm_regdump_uart.sv
// Two dumpers: A (BAUD 4, SETTLE 2, one register) and B (BAUD 3, SETTLE 2, 32 registers
// fed by a 2-cycle readout model); a UART decoder and line model check every byte.
module tb_sm_regdump_uart;
  logic clk;
  logic rst;

  sm_regdump_uart_if ifa ();
  sm_regdump_uart_if ifb ();

  sm_regdump_uart #(.BAUD_DIV(4), .SETTLE(2), .LAST_REG(0))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sm_regdump_uart #(.BAUD_DIV(3), .SETTLE(2), .LAST_REG(31)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // readout path for B: regData follows regAddr two cycles later
  logic [4:0] p1, p2;
  always @(posedge clk) begin
    p1 <= ifb.regAddr;
    p2 <= p1;
  end
  assign ifb.regData = {27'h0, p2};

  logic [1:0] tx_w, busy_w, done_w;
  logic [4:0] addr_w [2];
  assign tx_w      = {ifb.tx, ifa.tx};
  assign busy_w    = {ifb.busy, ifa.busy};
  assign done_w    = {ifb.done, ifa.done};
  assign addr_w[0] = ifa.regAddr;
  assign addr_w[1] = ifb.regAddr;

  int total = 0;
  int bad   = 0;
  int busy_cnt [2];
  int done_cnt [2];
  int nbytes [2];
  logic [4:0] prev_addr [2];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic [103:0] last13;

  bit         act  [2];
  int         dcnt [2];
  logic       bval [2];
  logic [7:0] dbyte [2];
  int         bi_v, pos_v;

  logic [7:0] lit_deadbeef [13] = '{8'h30, 8'h30, 8'h3A, 8'h44, 8'h45, 8'h41, 8'h44,
                                    8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

  function automatic int bd_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int last_of(input int d);
    return (d == 0) ? 0 : 31;
  endfunction

  function automatic logic [7:0] hexc(input int n);
    return 8'((n < 10) ? (48 + n) : (55 + n));
  endfunction

  task automatic check(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic push_line(input int d, input int idx, input logic [31:0] val, input int n);
    logic [7:0] b [13];
    b[0] = hexc(idx / 16);
    b[1] = hexc(idx % 16);
    b[2] = 8'h3A;
    for (int i = 0; i < 8; i++) b[3+i] = hexc(int'((val >> (28 - 4*i)) & 32'hF));
    b[11] = 8'h0D;
    b[12] = 8'h0A;
    for (int i = 0; i < n; i++) begin
      if (d == 0) exp_a.push_back(b[i]);
      else        exp_b.push_back(b[i]);
    end
  endtask

  task automatic byte_done(input int d, input logic [7:0] b);
    nbytes[d]++;
    if (d == 1) last13 = {last13[95:0], b};
    if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL extra_byte dut%0d: got %02h expected none", d, b);
    end else if (d == 0) begin
      check("uart_byte_a", b, exp_a.pop_front());
    end else begin
      check("uart_byte_b", b, exp_b.pop_front());
    end
  endtask

  // UART decoder: exact bit windows of BAUD_DIV cycles, sampled at negedge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act[d] = 1'b0;
      end else begin
        if (!act[d] && tx_w[d] == 1'b0) begin
          act[d]  = 1'b1;
          dcnt[d] = 0;
        end
        if (act[d]) begin
          bi_v  = dcnt[d] / bd_of(d);
          pos_v = dcnt[d] % bd_of(d);
          if (pos_v == 0) begin
            bval[d] = tx_w[d];
            if (bi_v == 9)      check("stop_bit", tx_w[d], 1'b1);
            else if (bi_v != 0) dbyte[d][bi_v-1] = tx_w[d];
          end else begin
            check("bit_hold", tx_w[d], bval[d]);
          end
          dcnt[d]++;
          if (dcnt[d] == 10 * bd_of(d)) begin
            act[d] = 1'b0;
            byte_done(d, dbyte[d]);
          end
        end
      end
    end
  end

  // per-cycle rules on the status outputs
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        prev_addr[d] = 5'd0;
      end else begin
        if (busy_w[d]) busy_cnt[d]++;
        if (done_w[d]) done_cnt[d]++;
        check("addr_range", int'(addr_w[d]) <= last_of(d), 1'b1);
        if (!busy_w[d]) check("tx_idle_high", tx_w[d], 1'b1);
        if (done_w[d])  check("done_busy_low", busy_w[d], 1'b0);
        if (addr_w[d] != prev_addr[d])
          check("addr_step", (addr_w[d] == prev_addr[d] + 5'd1) || (addr_w[d] == 5'd0), 1'b1);
        prev_addr[d] = addr_w[d];
      end
    end
  end

  task automatic pulse_start(input int d);
    @(negedge clk);
    if (d == 0) ifa.start = 1'b1;
    else        ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_done(input int d, input int limit);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (done_w[d]) seen = 1'b1;
    end
    #1;
    check("done_seen", seen, 1'b1);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      check("rst_tx",   tx_w[d],   1'b1);
      check("rst_busy", busy_w[d], 1'b0);
      check("rst_done", done_w[d], 1'b0);
      check("rst_addr", addr_w[d], 5'd0);
    end
  endtask

  initial begin
    logic [103:0] exp_last;
    int base;
    int n;
    bit hit;
    rst         = 1'b1;
    ifa.start   = 1'b0;
    ifb.start   = 1'b0;
    ifa.regData = 32'h0;
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0;
      done_cnt[d] = 0;
      nbytes[d]   = 0;
      act[d]      = 1'b0;
    end
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single line on A
    ifa.regData = 32'hDEADBEEF;
    for (int i = 0; i < 13; i++) exp_a.push_back(lit_deadbeef[i]);
    busy_cnt[0] = 0;
    done_cnt[0] = 0;
    pulse_start(0);
    wait_done(0, 2000);
    repeat (3) @(negedge clk);
    check("a_busy_cycles", busy_cnt[0], 538);
    check("a_done_count", done_cnt[0], 1);
    check("a_bytes_left", exp_a.size(), 0);
    check("a_addr_end", addr_w[0], 5'd0);

    // capture isolation on A
    ifa.regData = 32'hCAFEF00D;
    push_line(0, 0, 32'hCAFEF00D, 13);
    done_cnt[0] = 0;
    pulse_start(0);
    repeat (3) @(posedge clk);
    #1 ifa.regData = 32'h12345678;
    wait_done(0, 2000);
    repeat (3) @(negedge clk);
    check("a_iso_done", done_cnt[0], 1);
    check("a_iso_bytes_left", exp_a.size(), 0);

    // full dump on B with a start mid-dump that must be ignored
    for (int k = 0; k < 32; k++) push_line(1, k, 32'(k), 13);
    busy_cnt[1] = 0;
    done_cnt[1] = 0;
    pulse_start(1);
    repeat (5000) @(negedge clk);
    pulse_start(1);
    wait_done(1, 20000);
    exp_last = {"1F:0000001F", 8'h0D, 8'h0A};
    check("b_last_line", last13, exp_last);
    check("b_busy_cycles", busy_cnt[1], 13025);
    check("b_done_count", done_cnt[1], 1);
    check("b_bytes_left", exp_b.size(), 0);
    check("b_addr_end", addr_w[1], 5'd31);

    // start in the cycle after done, then reset during d3 of byte 5
    done_cnt[1] = 0;
    base = nbytes[1];
    push_line(1, 0, 32'h0, 5);
    pulse_start(1);
    #1;
    check("b_restart_busy", busy_w[1], 1'b1);
    check("b_restart_addr", addr_w[1], 5'd0);
    n   = 0;
    hit = 1'b0;
    while (n < 3000 && !hit) begin
      @(posedge clk);
      #2;
      n++;
      if (nbytes[1] == base + 5 && act[1] && dcnt[1] == 13) hit = 1'b1;
    end
    check("reach_byte5_d3", hit, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("b_abort_no_done", done_cnt[1], 0);
    check("b_abort_bytes", nbytes[1], base + 5);
    check("b_abort_left", exp_b.size(), 0);

    // clean dump after the reset
    for (int k = 0; k < 32; k++) push_line(1, k, 32'(k), 13);
    busy_cnt[1] = 0;
    pulse_start(1);
    wait_done(1, 20000);
    repeat (3) @(negedge clk);
    check("b2_busy_cycles", busy_cnt[1], 13025);
    check("b2_done_count", done_cnt[1], 1);
    check("b2_bytes_left", exp_b.size(), 0);
    check("b2_addr_end", addr_w[1], 5'd31);
    check("b2_last_line", last13, exp_last);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm_regdump_uart.md
Name: sm_regdump_uart

Overview:
- Debug master for the CPU register-readout port: drives regAddr, waits for the readout path to settle, captures regData, and streams each register as an ASCII hex line over a UART TX pin.
- Sits at board top beside the CPU; it is the initiator side of the regAddr/regData interface and replaces manual switch-driven register inspection.

Parameters:
- BAUD_DIV, 434, clk cycles per UART bit (>=2).
- SETTLE, 8, clk cycles between regAddr change and regData capture (>=1; must cover the input filter and readout latency).
- LAST_REG, 31, highest register index dumped (0..31); the dump covers 0..LAST_REG.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle dump request; sampled only in IDLE.
- regAddr  out  5  register index presented to the CPU readout port.
- regData  in  32  register value returned by the CPU readout port.
- tx  out  1  UART line, 8N1, idle high, LSB first.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, while rst=1): tx=1, busy=0, done=0, regAddr=0, state=IDLE, all counters cleared. A mid-frame reset truncates the frame; tx is high immediately.
- States: IDLE -> SETTLE -> CAPTURE -> LOAD -> SHIFT -> (LOAD | NEXT) -> (SETTLE | FINISH) -> IDLE.
- IDLE: on start=1, next cycle: regAddr=0, busy=1, settle counter=0, state=SETTLE. start is ignored in every other state; no queuing.
- SETTLE: count SETTLE cycles, then go to CAPTURE. CAPTURE: latch regData into the 32-bit shadow register in a single cycle. Later regData changes do not affect the line.
- Line format per register, 13 bytes: hex(idx[7:4]) hex(idx[3:0]) ':' 8 hex digits of shadow, MSB nibble first, then 0x0D 0x0A. Index is zero-extended to 8 bits.
- Hex digits are uppercase: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
- LOAD: select byte[charIdx] (0..12) into the shift register; the next cycle starts SHIFT.
- SHIFT: 10 bits: start(0), d0..d7, stop(1). Each bit is held exactly BAUD_DIV cycles by a baud counter that wraps at BAUD_DIV-1. There are no idle gaps between bytes beyond the one LOAD cycle.
- After the stop bit: if charIdx<12, increment charIdx and go to LOAD. Else go to NEXT.
- NEXT: if regAddr==LAST_REG, go to FINISH. Else increment regAddr, reset charIdx, and go to SETTLE.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, regAddr stays at LAST_REG, then IDLE.
- tx=1 in all states except during SHIFT bit periods.
- regAddr never exceeds LAST_REG and never wraps.
- The baud counter is 16 bits, the settle counter is 8 bits, and charIdx is 4 bits. Overflow cannot occur for legal parameters.
- Cycles per register = SETTLE + 1 (CAPTURE) + 13*(1 + 10*BAUD_DIV) + 1 (NEXT). FINISH adds 1 cycle per dump.

Test Plan:
- Reset: assert rst mid-simulation with no clock edge -> tx=1, busy=0, done=0, regAddr=0 immediately.
- Single line (BAUD_DIV=4, SETTLE=2, LAST_REG=0), regData=32'hDEADBEEF, pulse start -> decoded bytes 30 30 3A 44 45 41 44 42 45 45 46 0D 0A. Each bit lasts 4 cycles, done pulses once, and busy lasts 2+1+13*41+1+1=538 cycles.
- Full dump (LAST_REG=31), regData = {27'h0, regAddr} via a bench model with 2-cycle latency -> 32 lines. Line k reads "kk:000000kk" (hex), e.g. the last line is "1F:0000001F\r\n". regAddr steps 0..31 and ends at 31.
- Capture isolation: change regData to 32'h12345678 one cycle after CAPTURE with original 32'hCAFEF00D -> the line shows "CAFEF00D".
- Start during busy: pulse start mid-dump -> no restart, one done only. Start in the cycle after done -> a new dump begins at regAddr=0.
- Reset mid-byte: assert rst during bit d3 of byte 5 -> tx high at once, busy=0, no done. A subsequent start produces a complete, correct dump.
